// File: rtl/scs8hd_o221a_pipe_if.sv
// Streaming handshake bundle for the o221a pipeline: upstream operand word
// with valid/ready, downstream per-channel result with valid/ready.
interface scs8hd_o221a_pipe_if #(
  parameter int CH = 4,
  parameter int AW = 2,
  parameter int BW = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [CH*AW-1:0] a;
  logic [CH*BW-1:0] b;
  logic [CH-1:0]    c;
  logic             inv;
  logic             out_valid;
  logic             out_ready;
  logic [CH-1:0]    x;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, c, inv, out_ready,
    input  in_ready, out_valid, x
  );

  // Pipeline side: consumes operands and presents results.
  modport slave (
    input  in_valid, a, b, c, inv, out_ready,
    output in_ready, out_valid, x
  );
endinterface

// File: rtl/scs8hd_o221a_pipe.sv
// Multi-channel registered o221a / o221ai cell with valid/ready handshake.
// Each channel computes (|A) & (|B) & C, optionally inverted per word, and
// the result word is buffered in a 2-entry FIFO. Saturating per-channel
// counters track how many delivered results had a 1 in that channel.
module scs8hd_o221a_pipe #(
  parameter int CH   = 4,
  parameter int AW   = 2,
  parameter int BW   = 2,
  parameter int CNTW = 8
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  scs8hd_o221a_pipe_if.slave   bus,
  input  logic                 cnt_clr,
  output logic [CH*CNTW-1:0]   hit_cnt
`ifdef SC_USE_PG_PIN
  ,
  input  logic                 vpwr,
  input  logic                 vgnd,
  input  logic                 vpb,
  input  logic                 vnb
`endif
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply1 vpb;
  supply0 vgnd;
  supply0 vnb;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CH-1:0]               head_q, head_d;
  logic [CH-1:0]               tail_q, tail_d;
  logic                        rdy_q, rdy_d;
  logic [CH-1:0][CNTW-1:0]     cnt_q, cnt_d;

  logic [CH-1:0]               new_x;
  logic                        accept;
  logic                        xfer;
  logic                        pg_ok;

  // Supplies only matter when the power pins are exposed; tied off they fold away.
  assign pg_ok = vpwr & vpb & ~vgnd & ~vnb;

  // in_ready is held low through reset and for the cycle it is released,
  // and never looks at out_ready, so it is a pure function of state.
  assign bus.in_ready  = rdy_q & pg_ok & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.x         = (state_q != EMPTY) ? head_q : '0;
  assign hit_cnt       = cnt_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign xfer   = bus.out_valid & bus.out_ready;

  // Per-channel o221a function with the word-level inversion applied.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_x = '0;
    for (int k = 0; k < CH; k++) begin
      new_x[k] = (|bus.a[k*AW +: AW]) & (|bus.b[k*BW +: BW]) & bus.c[k];
    end
    new_x = new_x ^ {CH{bus.inv}};
  end

  // FIFO occupancy and entry movement; head is always the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    rdy_d   = 1'b1;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = new_x;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          head_d = new_x;
        end else if (accept) begin
          tail_d  = new_x;
          state_d = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Saturating hit counters; a clear wins over a same-edge increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < CH; k++) begin
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (xfer && head_q[k] && (cnt_q[k] != {CNTW{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNTW'(1);
      end
    end
  end

  // State, FIFO storage and counters, all cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= EMPTY;
      // NOTE: the two FIFO entries are tiny, so they are reset too; this keeps x free of X after reset.
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/scs8hd_o221a_pipe.md
SCS8HD_O221A_PIPE -- requirements
Module: scs8hd_o221a_pipe

Interface
REQ-001 The block SHALL have parameter CH, default 4: number of independent o221a channels.
REQ-002 The block SHALL have parameter AW, default 2: OR width of the A group per channel (AW >= 1).
REQ-003 The block SHALL have parameter BW, default 2: OR width of the B group per channel (BW >= 1).
REQ-004 The block SHALL have parameter CNTW, default 8: width of each per-channel hit counter.
REQ-005 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RESETB, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port a, input, CH*AW bits: A operands; channel k uses a[k*AW +: AW].
REQ-010 The block SHALL have port b, input, CH*BW bits: B operands; channel k uses b[k*BW +: BW].
REQ-011 The block SHALL have port c, input, CH bits: C1 operand per channel.
REQ-012 The block SHALL have port inv, input, 1 bit: per-word mode; 0 = o221a, 1 = o221ai (inverted output).
REQ-013 The block SHALL have port out_valid, output, 1 bit: x holds a valid result.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts x.
REQ-015 The block SHALL have port x, output, CH bits: registered result per channel.
REQ-016 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of all hit counters.
REQ-017 The block SHALL have port hit_cnt, output, CH*CNTW bits: saturating per-channel count of delivered x=1 results.
REQ-018 Under SC_USE_PG_PIN the block SHALL add inputs vpwr, vgnd, vpb, vnb; otherwise these SHALL be internal supply1/supply0 nets.

Function
REQ-019 Per channel k, f_k SHALL equal (|A_k) & (|B_k) & c[k], and x[k] SHALL equal f_k XOR inv, evaluated at acceptance.
REQ-020 Input acceptance SHALL occur on a rising edge where in_valid & in_ready; output transfer SHALL occur where out_valid & out_ready.
REQ-021 Results SHALL be buffered in a 2-entry FIFO (states EMPTY, ONE, FULL); x and out_valid SHALL present the head entry.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL NOT depend combinationally on out_ready.
REQ-023 Latency SHALL be 1 cycle: a word accepted at edge n in EMPTY SHALL give out_valid=1 with its x after edge n.
REQ-024 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without transfer; ONE->EMPTY on transfer without accept; ONE stays ONE on simultaneous accept and transfer; FULL->ONE on transfer.
REQ-025 Output order SHALL equal acceptance order; x SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 In EMPTY, out_valid SHALL be 0 and x SHALL be all-zero.
REQ-027 On each transfer, hit_cnt[k] SHALL increment by 1 when the transferred x[k]=1, and SHALL saturate at 2^CNTW-1 without wrapping.
REQ-028 cnt_clr SHALL zero all counters at the edge and SHALL take priority over a simultaneous increment; FIFO state SHALL be unaffected.
REQ-029 inv SHALL be captured per word; changing inv SHALL NOT alter words already buffered.

Reset
REQ-030 RESETB=0 SHALL immediately and asynchronously force EMPTY, out_valid=0, x=0, hit_cnt=0, and in_ready=0.
REQ-031 in_ready SHALL return to 1 on the first rising CLK edge after RESETB deasserts; buffered words SHALL be discarded by a mid-operation reset.

Verification
REQ-032 Reset then a=8'h01, b=8'h02, c=4'h1, inv=0, one accept -> next cycle out_valid=1, x=4'b0001.
REQ-033 Same word with inv=1 -> x=4'b1110; the counters increment only for channels 1-3 on transfer.
REQ-034 out_ready=0, three back-to-back words W0, W1, W2 -> in_ready=0 after W1 is accepted; release -> W0, W1, W2 delivered in order, none lost.
REQ-035 CNTW=2, channel 0 forced to 1 for 5 transfers -> hit_cnt[1:0] stays at 3; cnt_clr together with a transfer -> 0.
REQ-036 RESETB pulsed low mid-cycle in FULL -> out_valid=0 and hit_cnt=0 without a clock edge.
REQ-037 Continuous in_valid=1 and out_ready=1 -> one transfer per cycle, state remains ONE, x equals the previous cycle's inputs.
